vector_issue_seq: RTL and testbench

Single-issue sequencer directly upstream of the combinational vector ALU (vector_operations).
- Accepts decoded custom vector instructions over a valid/ready handshake.
- Reads operands from an internal vector register file and drives the ALU operand/control inputs from registers.
- Captures the ALU result and writes it back, then signals completion with a one-cycle pulse.

---
 rtl/vector_pkg.sv | 34 +++
 rtl/vector_regfile.sv | 41 ++++
 rtl/vector_issue_seq.sv | 170 +++++++++++++++++
 tb/tb_vector_issue_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared encodings, FSM state type and legality check for the vector issue sequencer.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package vector_pkg;

  localparam logic [1:0] MODE_VV = 2'b00;
  localparam logic [1:0] MODE_VX = 2'b01;
  localparam logic [1:0] MODE_VI = 2'b10;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SUB = 3'b001;
  localparam logic [2:0] F3_MUL = 3'b010;
  localparam logic [2:0] F3_AND = 3'b011;
  localparam logic [2:0] F3_OR  = 3'b100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } state_t;

  // An instruction is legal only when both its mode and its operation are defined encodings.
  function automatic logic is_legal(input logic [1:0] mode, input logic [2:0] funct3);
    logic mode_ok;
    logic f3_ok;
    mode_ok = (mode == MODE_VV) || (mode == MODE_VX) || (mode == MODE_VI);
    f3_ok   = (funct3 == F3_ADD) || (funct3 == F3_SUB) || (funct3 == F3_MUL) ||
              (funct3 == F3_AND) || (funct3 == F3_OR);
    return mode_ok && f3_ok;
  endfunction

endpackage

// File: rtl/vector_regfile.sv
// vector_regfile: NUM_VREGS x VW register file, two combinational read ports, one synchronous write port.
// Latency: reads are combinational; writes land at the clock edge.
// Backpressure: none; writeback wins over preload (the sequencer never asserts both together).
module vector_regfile #(
  parameter int NUM_VREGS = 8,
  parameter int VW        = 256,
  parameter int AW        = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [VW-1:0] rd_data_a,
  output logic [VW-1:0] rd_data_b,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [VW-1:0] ld_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [VW-1:0] wb_data
);

  logic [VW-1:0] mem [NUM_VREGS];

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

  // Storage: clear on reset, otherwise take the single arbitrated write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_en) begin
      mem[wb_addr] <= wb_data;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

endmodule

// File: rtl/vector_issue_seq.sv
// vector_issue_seq: single-issue sequencer; reads operands, drives registered ALU inputs, writes the result back.
// Latency: accept at edge T -> done pulse in the cycle after edge T+3; one instruction per 4 cycles.
// Backpressure: instr_ready high only in IDLE; preload honoured only in IDLE. Optional VISSUE_PERF_EN adds perf counters.
module vector_issue_seq
  import vector_pkg::*;
#(
  parameter  int VECTOR_LENGTH = 8,
  parameter  int DATA_WIDTH    = 32,
  parameter  int NUM_VREGS     = 8,
  localparam int VW            = VECTOR_LENGTH * DATA_WIDTH,
  localparam int AW            = $clog2(NUM_VREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [AW-1:0]         instr_vd,
  input  logic [AW-1:0]         instr_vs1,
  input  logic [AW-1:0]         instr_vs2,
  input  logic [DATA_WIDTH-1:0] instr_scalar,
  input  logic [1:0]            instr_mode,
  input  logic [2:0]            instr_funct3,
  input  logic                  ld_valid,
  input  logic [AW-1:0]         ld_addr,
  input  logic [VW-1:0]         ld_data,
  output logic [VW-1:0]         alu_vector_a,
  output logic [VW-1:0]         alu_vector_b,
  output logic [DATA_WIDTH-1:0] alu_scalar,
  output logic [1:0]            alu_mode,
  output logic [2:0]            alu_funct3,
  input  logic [VW-1:0]         alu_result,
  output logic                  done,
  output logic [AW-1:0]         done_vd,
  output logic                  err
`ifdef VISSUE_PERF_EN
  ,
  output logic [31:0]           perf_retired,
  output logic [15:0]           perf_errors
`endif
);

  state_t state_q;
  state_t state_d;

  logic [AW-1:0]         vd_q;
  logic [AW-1:0]         vs1_q;
  logic [AW-1:0]         vs2_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [1:0]            mode_q;
  logic [2:0]            funct3_q;
  logic [VW-1:0]         result_q;
  logic [VW-1:0]         rd_a;
  logic [VW-1:0]         rd_b;

  assign instr_ready = (state_q == IDLE);

  // Preload shares the write port with writeback; the two are never active in the same state.
  vector_regfile #(
    .NUM_VREGS (NUM_VREGS),
    .VW        (VW),
    .AW        (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (vs1_q),
    .rd_addr_b (vs2_q),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b),
    .ld_en     ((state_q == IDLE) && ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_en     (state_q == WB),
    .wb_addr   (vd_q),
    .wb_data   (result_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: legal instructions walk READ->EXEC->WB, illegal ones take one ERR cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = is_legal(instr_mode, instr_funct3) ? READ : ERR;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the instruction fields at the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vd_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      scalar_q <= '0;
      mode_q   <= '0;
      funct3_q <= '0;
    end else if ((state_q == IDLE) && instr_valid) begin
      vd_q     <= instr_vd;
      vs1_q    <= instr_vs1;
      vs2_q    <= instr_vs2;
      scalar_q <= instr_scalar;
      mode_q   <= instr_mode;
      funct3_q <= instr_funct3;
    end
  end

  // Drive the ALU from registers, loaded once per legal instruction; B is zero unless vector-vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_vector_a <= '0;
      alu_vector_b <= '0;
      alu_scalar   <= '0;
      alu_mode     <= '0;
      alu_funct3   <= '0;
    end else if (state_q == READ) begin
      alu_vector_a <= rd_a;
      alu_vector_b <= (mode_q == MODE_VV) ? rd_b : '0;
      alu_scalar   <= scalar_q;
      alu_mode     <= mode_q;
      alu_funct3   <= funct3_q;
    end
  end

  // Capture the combinational ALU output one cycle after its operands settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (state_q == EXEC) begin
      result_q <= alu_result;
    end
  end

  // Completion and error pulses, registered so they coincide with the return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      done_vd <= '0;
      err     <= 1'b0;
    end else begin
      done    <= (state_q == WB);
      done_vd <= (state_q == WB) ? vd_q : '0;
      err     <= (state_q == ERR);
    end
  end

`ifdef VISSUE_PERF_EN
  // Free-running retire/error counters, wrapping naturally at their widths.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_errors  <= '0;
    end else begin
      if (state_q == WB)  perf_retired <= perf_retired + 32'd1;
      if (state_q == ERR) perf_errors  <= perf_errors + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_issue_seq.sv
// tb_vector_issue_seq: randomized and directed bench for vector_issue_seq against a transaction-level model.
// Latency: not applicable.
// Backpressure: stimulus waits on instr_ready with bounded loops.
module tb_vector_issue_seq;

  localparam int VL = 8;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int VW = VL * DW;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [AW-1:0] instr_vd = '0;
  logic [AW-1:0] instr_vs1 = '0;
  logic [AW-1:0] instr_vs2 = '0;
  logic [DW-1:0] instr_scalar = '0;
  logic [1:0]    instr_mode = '0;
  logic [2:0]    instr_funct3 = '0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [VW-1:0] ld_data = '0;
  logic [VW-1:0] alu_vector_a;
  logic [VW-1:0] alu_vector_b;
  logic [DW-1:0] alu_scalar;
  logic [1:0]    alu_mode;
  logic [2:0]    alu_funct3;
  logic [VW-1:0] alu_result;
  logic          done;
  logic [AW-1:0] done_vd;
  logic          err;
`ifdef VISSUE_PERF_EN
  logic [31:0]   perf_retired;
  logic [15:0]   perf_errors;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vector_issue_seq dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_vd     (instr_vd),
    .instr_vs1    (instr_vs1),
    .instr_vs2    (instr_vs2),
    .instr_scalar (instr_scalar),
    .instr_mode   (instr_mode),
    .instr_funct3 (instr_funct3),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_vector_a (alu_vector_a),
    .alu_vector_b (alu_vector_b),
    .alu_scalar   (alu_scalar),
    .alu_mode     (alu_mode),
    .alu_funct3   (alu_funct3),
    .alu_result   (alu_result),
    .done         (done),
    .done_vd      (done_vd),
    .err          (err)
`ifdef VISSUE_PERF_EN
    ,
    .perf_retired (perf_retired),
    .perf_errors  (perf_errors)
`endif
  );

  // Reference lane-wise ALU: second operand is vector B for VV, the scalar otherwise.
  function automatic logic [VW-1:0] alu_fn(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                           input logic [DW-1:0] s, input logic [1:0] m,
                                           input logic [2:0] f);
    logic [VW-1:0] r;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    r = '0;
    for (int i = 0; i < VL; i++) begin
      x = a[i*DW +: DW];
      y = (m == 2'b00) ? b[i*DW +: DW] : s;
      case (f)
        3'd0:    r[i*DW +: DW] = x + y;
        3'd1:    r[i*DW +: DW] = x - y;
        3'd2:    r[i*DW +: DW] = x * y;
        3'd3:    r[i*DW +: DW] = x & y;
        3'd4:    r[i*DW +: DW] = x | y;
        default: r[i*DW +: DW] = '0;
      endcase
    end
    return r;
  endfunction

  assign alu_result = alu_fn(alu_vector_a, alu_vector_b, alu_scalar, alu_mode, alu_funct3);

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VL; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [VW-1:0] m_reg [NR];
  bit            m_live  = 1'b0;
  int            m_left  = 0;   // cycles until the in-flight instruction finishes
  bit            m_legal = 1'b0;
  logic [VW-1:0] p_a, p_b, p_res;
  logic [DW-1:0] p_s;
  logic [1:0]    p_m;
  logic [2:0]    p_f;
  logic [AW-1:0] p_vd;
  logic [VW-1:0] e_a, e_b;
  logic [DW-1:0] e_s;
  logic [1:0]    e_m;
  logic [2:0]    e_f;
  logic          e_done, e_err;
  logic [AW-1:0] e_vd;
  logic [31:0]   m_ret;
  logic [15:0]   m_errc;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_reg[i] = '0;
      m_left = 0; e_a = '0; e_b = '0; e_s = '0; e_m = '0; e_f = '0;
      e_done = 1'b0; e_err = 1'b0; e_vd = '0; m_ret = '0; m_errc = '0;
      m_live = 1'b1;
    end else begin
      e_done = 1'b0; e_err = 1'b0; e_vd = '0;
      if (m_left > 0) begin
        m_left--;
        if (m_legal && m_left == 2) begin
          e_a = p_a; e_b = p_b; e_s = p_s; e_m = p_m; e_f = p_f;
        end
        if (m_left == 0) begin
          if (m_legal) begin
            m_reg[p_vd] = p_res; e_done = 1'b1; e_vd = p_vd; m_ret = m_ret + 32'd1;
          end else begin
            e_err = 1'b1; m_errc = m_errc + 16'd1;
          end
        end
      end else begin
        if (ld_valid) m_reg[ld_addr] = ld_data;
        if (instr_valid) begin
          m_legal = (instr_mode != 2'b11) && (instr_funct3 <= 3'd4);
          m_left  = m_legal ? 3 : 1;
          p_a   = m_reg[instr_vs1];
          p_b   = (instr_mode == 2'b00) ? m_reg[instr_vs2] : '0;
          p_s   = instr_scalar;
          p_m   = instr_mode;
          p_f   = instr_funct3;
          p_vd  = instr_vd;
          p_res = alu_fn(p_a, p_b, p_s, p_m, p_f);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("instr_ready", VW'(instr_ready), VW'(m_left == 0));
      chk("done", VW'(done), VW'(e_done));
      chk("done_vd", VW'(done_vd), VW'(e_vd));
      chk("err", VW'(err), VW'(e_err));
      chk("alu_vector_a", alu_vector_a, e_a);
      chk("alu_vector_b", alu_vector_b, e_b);
      chk("alu_scalar", VW'(alu_scalar), VW'(e_s));
      chk("alu_mode", VW'(alu_mode), VW'(e_m));
      chk("alu_funct3", VW'(alu_funct3), VW'(e_f));
`ifdef VISSUE_PERF_EN
      chk("perf_retired", VW'(perf_retired), VW'(m_ret));
      chk("perf_errors", VW'(perf_errors), VW'(m_errc));
`endif
    end
  end

  // ---------------- stimulus helpers (all entered just after a negedge) ----------------
  task automatic wait_idle();
    int g = 0;
    while (!instr_ready && g < 16) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 16) begin
      n_fail++;
      $display("FAIL wait_idle: instr_ready still %0b after %0d cycles, required 1", instr_ready, g);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [VW-1:0] d);
    wait_idle();
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] vd, input logic [AW-1:0] vs1, input logic [AW-1:0] vs2,
                       input logic [DW-1:0] s, input logic [1:0] m, input logic [2:0] f);
    int g = 0;
    instr_vd = vd; instr_vs1 = vs1; instr_vs2 = vs2; instr_scalar = s;
    instr_mode = m; instr_funct3 = f; instr_valid = 1'b1;
    while (!instr_ready && g < 16) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 16) begin
      n_fail++;
      $display("FAIL issue_accept: not accepted after %0d cycles, required acceptance", g);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;
    int done_cnt;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready", VW'(instr_ready), VW'(1));
    chk("reset_alu_a", alu_vector_a, VW'(0));
    chk("reset_done", VW'(done), VW'(0));
    rst = 1'b0;
    @(negedge clk);

    // VV add with literal latency checks
    preload(3'd1, {8{32'h2}});
    preload(3'd2, {8{32'h3}});
    issue(3'd3, 3'd1, 3'd2, 32'd0, 2'b00, 3'd0);
    @(negedge clk);
    chk("vv_add_a", alu_vector_a, {8{32'h2}});
    chk("vv_add_b", alu_vector_b, {8{32'h3}});
    chk("vv_add_no_done_t1", VW'(done), VW'(0));
    @(negedge clk);
    chk("vv_add_no_done_t2", VW'(done), VW'(0));
    @(negedge clk);
    chk("vv_add_done", VW'(done), VW'(1));
    chk("vv_add_done_vd", VW'(done_vd), VW'(3));

    // VV or of v3 with itself, then read it back
    issue(3'd4, 3'd3, 3'd3, 32'd0, 2'b00, 3'd4);
    wait_idle();
    chk("model_v4", m_reg[4], {8{32'h5}});
    issue(3'd5, 3'd4, 3'd4, 32'd0, 2'b00, 3'd4);
    @(negedge clk);
    chk("readback_v4", alu_vector_a, {8{32'h5}});

    // VX sub
    issue(3'd6, 3'd1, 3'd7, 32'd1, 2'b01, 3'd1);
    @(negedge clk);
    chk("vx_mode", VW'(alu_mode), VW'(1));
    chk("vx_b_zero", alu_vector_b, VW'(0));
    chk("vx_scalar", VW'(alu_scalar), VW'(1));
    @(negedge clk);
    @(negedge clk);
    chk("vx_done", VW'(done), VW'(1));
    chk("vx_done_vd", VW'(done_vd), VW'(6));
    issue(3'd7, 3'd6, 3'd6, 32'd0, 2'b00, 3'd4);
    @(negedge clk);
    chk("readback_v6", alu_vector_a, {8{32'h1}});

    // Illegal mode, then illegal funct3, both targeting v6
    wait_idle();
    issue(3'd6, 3'd1, 3'd2, 32'd0, 2'b11, 3'd0);
    chk("ill_mode_no_err_yet", VW'(err), VW'(0));
    @(negedge clk);
    chk("ill_mode_err", VW'(err), VW'(1));
    chk("ill_mode_no_done", VW'(done), VW'(0));
    chk("ill_mode_ready", VW'(instr_ready), VW'(1));
    issue(3'd6, 3'd1, 3'd2, 32'd0, 2'b00, 3'd5);
    @(negedge clk);
    chk("ill_f3_err", VW'(err), VW'(1));
    chk("ill_f3_ready", VW'(instr_ready), VW'(1));
    @(negedge clk);
    chk("ill_f3_err_one_cycle", VW'(err), VW'(0));
    issue(3'd0, 3'd6, 3'd6, 32'd0, 2'b00, 3'd4);
    @(negedge clk);
    chk("v6_unchanged", alu_vector_a, {8{32'h1}});

    // instr_valid held high back-to-back
    wait_idle();
    @(negedge clk);
    rdy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      instr_valid  = 1'b1;
      instr_vd     = AW'($urandom_range(0, NR - 1));
      instr_vs1    = AW'($urandom_range(0, NR - 1));
      instr_vs2    = AW'($urandom_range(0, NR - 1));
      instr_scalar = $urandom;
      instr_mode   = 2'($urandom_range(0, 2));
      instr_funct3 = 3'($urandom_range(0, 4));
      if (instr_ready) rdy_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("b2b_ready_cnt", VW'(rdy_cnt), VW'(10));
    chk("b2b_done_cnt", VW'(done_cnt), VW'(10));

    // Reset during EXEC
    preload(3'd1, {8{32'h9}});
    issue(3'd2, 3'd1, 3'd1, 32'd0, 2'b00, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_exec_no_done", VW'(done), VW'(0));
    chk("rst_exec_alu_a", alu_vector_a, VW'(0));
    chk("rst_exec_ready", VW'(instr_ready), VW'(1));
    @(negedge clk);
    chk("rst_exec_no_late_done", VW'(done), VW'(0));
    issue(3'd3, 3'd1, 3'd2, 32'd0, 2'b00, 3'd4);
    @(negedge clk);
    chk("rst_vregs_a", alu_vector_a, VW'(0));
    chk("rst_vregs_b", alu_vector_b, VW'(0));
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_done", VW'(done), VW'(1));

    // Randomized traffic: overlapping preload/issue, illegal encodings, occasional reset
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ld_valid     = ($urandom_range(0, 2) == 0);
      ld_addr      = AW'($urandom_range(0, NR - 1));
      ld_data      = rand_vec();
      instr_valid  = ($urandom_range(0, 1) == 0);
      instr_vd     = AW'($urandom_range(0, NR - 1));
      instr_vs1    = AW'($urandom_range(0, NR - 1));
      instr_vs2    = AW'($urandom_range(0, NR - 1));
      instr_scalar = $urandom;
      instr_mode   = 2'($urandom_range(0, 3));
      instr_funct3 = 3'($urandom_range(0, 5));
      @(negedge clk);
    end
    rst = 1'b0; ld_valid = 1'b0; instr_valid = 1'b0;
    repeat (5) @(negedge clk);

`ifdef VISSUE_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(3'd1, 3'd0, 3'd0, 32'd1, 2'b01, 3'd0);
    issue(3'd2, 3'd1, 3'd1, 32'd0, 2'b00, 3'd0);
    issue(3'd3, 3'd1, 3'd1, 32'd0, 2'b11, 3'd0);
    issue(3'd3, 3'd2, 3'd1, 32'd2, 2'b10, 3'd2);
    issue(3'd4, 3'd2, 3'd1, 32'd0, 2'b00, 3'd6);
    issue(3'd4, 3'd2, 3'd3, 32'd0, 2'b00, 3'd1);
    issue(3'd5, 3'd4, 3'd4, 32'd0, 2'b00, 3'd3);
    wait_idle();
    chk("perf_retired_5", VW'(perf_retired), VW'(5));
    chk("perf_errors_2", VW'(perf_errors), VW'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("perf_retired_rst", VW'(perf_retired), VW'(0));
    chk("perf_errors_rst", VW'(perf_errors), VW'(0));
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
